// File: rtl/qam_pkg.sv
// qam_pkg: mode codes, constellation levels and symbol-width helper for the QAM mapper
package qam_pkg;
    localparam logic [1:0] MODE_BPSK  = 2'd0;
    localparam logic [1:0] MODE_QPSK  = 2'd1;
    localparam logic [1:0] MODE_16QAM = 2'd2;
    localparam int LVL_P1 = 1;
    localparam int LVL_N1 = -1;
    localparam int LVL_P3 = 3;
    localparam int LVL_N3 = -3;
    typedef enum logic {IDLE, EMIT} state_e;
    // Reserved mode 3 falls through to the QPSK width
    function automatic int unsigned bits_per_symbol(input logic [1:0] mode);
        return mode == MODE_BPSK ? 1 : mode == MODE_16QAM ? 4 : 2;
    endfunction
endpackage

// File: rtl/qam_symbol_lut.sv
// qam_symbol_lut: maps the four MSBs of the shift register to a Gray-coded {im, re} pair scaled by AMP
module qam_symbol_lut
    import qam_pkg::*;
#(
    parameter int COMP_W = 8,
    parameter int AMP    = 1
) (
    input  logic [1:0]          mode_i,
    input  logic [3:0]          bits_i,
    output logic [2*COMP_W-1:0] sym_o
);
    int re;
    int im;
    always_comb begin
        re = bits_i[3] ? LVL_P1 : LVL_N1;
        im = 0;
        if (mode_i == MODE_16QAM) begin
            re = bits_i[3] ? (bits_i[2] ? LVL_P1 : LVL_P3) : (bits_i[2] ? LVL_N1 : LVL_N3);
            im = bits_i[1] ? (bits_i[0] ? LVL_N1 : LVL_N3) : (bits_i[0] ? LVL_P1 : LVL_P3);
        end else if (mode_i != MODE_BPSK) begin
            im = bits_i[2] ? LVL_N1 : LVL_P1;
        end
        sym_o = {COMP_W'(im * AMP), COMP_W'(re * AMP)};
    end
endmodule

// File: rtl/qam_mapper.sv
// qam_mapper: serialises input words into Gray-coded BPSK/QPSK/16-QAM symbols with valid/ready on both sides
module qam_mapper
    import qam_pkg::*;
#(
    parameter int DIN_W  = 8,
    parameter int COMP_W = 8,
    parameter int AMP    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode,
    input  logic [DIN_W-1:0]    in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic [2*COMP_W-1:0] out_data,
    output logic                out_valid,
    output logic                out_last,
    input  logic                out_ready
);
    localparam int RW = $clog2(DIN_W + 1);
    state_e              state_q, state_d;
    logic [DIN_W-1:0]    sr_q, sr_d;
    logic [1:0]          mode_q, mode_d;
    logic                last_q, last_d;
    logic                out_last_q, out_last_d;
    logic [RW-1:0]       rem_q, rem_d;
    logic [2*COMP_W-1:0] data_q, data_d, sym;
    logic                in_acc, out_acc;
    assign out_valid = state_q == EMIT;
    assign out_data  = data_q;
    assign out_last  = out_last_q;
    assign in_ready  = !rst && (state_q == IDLE || (rem_q == RW'(1) && out_ready));
    assign in_acc    = in_valid && in_ready;
    assign out_acc   = out_valid && out_ready;
    // The LUT looks at next-state values so the output register always holds the symbol on display
    qam_symbol_lut #(.COMP_W(COMP_W), .AMP(AMP)) u_lut (
        .mode_i(mode_d),
        .bits_i(sr_d[DIN_W-1 -: 4]),
        .sym_o (sym)
    );
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        mode_d  = mode_q;
        last_d  = last_q;
        rem_d   = rem_q;
        if (out_acc) begin
            sr_d    = sr_q << bits_per_symbol(mode_q);
            rem_d   = rem_q - RW'(1);
            state_d = rem_q == RW'(1) ? IDLE : EMIT;
        end
        if (in_acc) begin
            sr_d    = in_data;
            mode_d  = mode;
            last_d  = in_last;
            rem_d   = RW'(DIN_W / bits_per_symbol(mode));
            state_d = EMIT;
        end
        data_d     = !(in_acc || out_acc) ? data_q : state_d == EMIT ? sym : '0;
        out_last_d = state_d == EMIT && last_d && rem_d == RW'(1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            mode_q     <= MODE_BPSK;
            last_q     <= 1'b0;
            rem_q      <= '0;
            data_q     <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            mode_q     <= mode_d;
            last_q     <= last_d;
            rem_q      <= rem_d;
            data_q     <= data_d;
            out_last_q <= out_last_d;
        end
    end
endmodule

// File: doc/qam_mapper.md
Name: qam_mapper

Overview:
- Parametrised successor to the fixed QPSK mapper: accepts a byte stream and emits Gray-coded complex symbols.
- Runtime mode selects BPSK, QPSK or 16-QAM.
- Adds valid/ready back-pressure on both sides, symbol serialisation from multi-bit input words, amplitude scaling and frame-last propagation.
- Sits between the scrambler/byte source and the IFFT/pulse-shaping input of the VLC transmit chain.

Parameters:
- DIN_W, 8: input word width; must be a multiple of 4.
- COMP_W, 8: signed width of each I/Q component.
- AMP, 1: unit amplitude; levels are ±AMP and ±3·AMP; 3·AMP must fit signed COMP_W.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- mode  in  2  0=BPSK, 1=QPSK, 2=16QAM, 3=reserved (treated as QPSK); sampled only on input accept
- in_data  in  DIN_W  payload word
- in_valid  in  1  in_data valid
- in_last  in  1  word is last of frame
- in_ready  out  1  mapper can accept a word this cycle
- out_data  out  2*COMP_W  packed {im, re}, two's complement
- out_valid  out  1  out_data valid
- out_last  out  1  final symbol of a word that carried in_last
- out_ready  in  1  downstream accepts out_data

Behaviour:
- Single clock; reset is synchronous and active-high (rst sampled on rising clk).
- Reset values: out_valid=0, out_data=0, out_last=0, state=IDLE. in_ready=0 while rst=1.
- Bits per symbol: BPSK 1, QPSK 2, 16QAM 4. Symbols per word: N = DIN_W / bits. Bits are consumed MSB first.
- Input accept = in_valid & in_ready. On accept: latch word into shift register, latch mode and in_last, load remaining=N, and present the first symbol.
- Latency: a word accepted at edge k gives out_valid=1 after edge k; the first symbol is registered.
- Output hold: while out_valid & !out_ready, out_data and out_last are stable.
- On output accept (out_valid & out_ready): shift by bits and decrement remaining. The next symbol appears the following cycle, or out_valid falls if none remain and no new word was accepted.
- in_ready = (state==IDLE) | (state==EMIT & remaining==1 & out_ready). This gives back-to-back words with no bubble: one symbol per cycle sustained.
- FSM:
  - IDLE: no pending symbol. -> EMIT on input accept.
  - EMIT: out_valid=1. Stays in EMIT while symbols remain or a new word is accepted with the last symbol. -> IDLE when the last symbol is accepted and no new word is accepted.
- Mapping, signed values × AMP:
  - BPSK: b=1 -> re=+1, im=0. b=0 -> re=-1, im=0.
  - QPSK {b1,b0}: re = b1 ? +1 : -1. im = b0 ? -1 : +1. Hence 11 -> 1-j, 01 -> -1-j, 10 -> 1+j, 00 -> -1+j.
  - 16QAM {b3,b2,b1,b0}:
    - re sign = b3 ? + : -, magnitude = b2 ? 1 : 3. Gray sequence 00,01,11,10 = -3,-1,+1,+3.
    - im sign = b1 ? - : +, magnitude = b0 ? 1 : 3.
  - Components are sign-extended to COMP_W.
- out_last=1 only on symbol N of a word latched with in_last=1.
- Mode changes while in EMIT have no effect until the next input accept.
- rst asserted mid-word: pending symbols are discarded, outputs go to reset values next edge, no partial symbol is emitted.
- Input accept while out_valid & !out_ready cannot occur, because in_ready requires out_ready when in EMIT.

Decomposition:
- qam_pkg: mode localparams (MODE_BPSK/QPSK/16QAM), bits_per_symbol function, level encoding constants (±1, ±3).
- Sub-module qam_symbol_lut: combinational {mode, 4 MSBs of shift register} -> {im, re} scaled by AMP.
- The top level holds the FSM, shift register, counter and output register.

Test Plan:
- QPSK, DIN_W=8, in_data=8'b11_01_10_00, out_ready=1 -> four symbols on consecutive cycles: {im,re} = {-1,+1}, {-1,-1}, {+1,+1}, {+1,-1}, i.e. 16'hFF01, FFFF, 0101, 01FF; in_ready high on the 4th.
- 16QAM, in_data=8'b1000_0111 -> re=+3, im=+3, then re=-1, im=-1 (16'h0303, 16'hFFFF); AMP=2 run gives 16'h0606, 16'hFEFE.
- BPSK, in_data=8'hA5, in_last=1 -> 8 symbols re=+1,-1,+1,-1,-1,+1,-1,+1 with im=0; out_last=1 only on the 8th.
- Back-pressure: out_ready toggling 1,0,0,1 during QPSK word -> out_data stable while stalled, no symbol lost or duplicated, in_ready=0 throughout.
- Back-to-back QPSK words, in_valid=1 continuously, out_ready=1 -> 8 symbols in 8 cycles, no bubble; mode switched to 16QAM mid-word only affects the second word.
- rst pulsed after 2nd symbol of a 16QAM word -> next cycle out_valid=0, out_data=0; the following word starts cleanly at its first symbol.
